// File: rtl/serial_adder_pkg.sv
// Shared definitions for the digit-serial adder/subtractor.
//   state_t   : FSM encoding (IDLE, RUN, DONE)
//   cnt_width : width of a counter that must hold values 0..n-1 (at least 1 bit)
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/serial_adder_digit_adder.sv
// Combinational ripple of DIGIT full-adder cells.
//   x, y     : digit operands
//   cin      : carry into the least significant bit
//   s        : digit sum
//   cout     : carry out of the top bit
//   c_msb_in : carry into the top bit (used for signed overflow)
module digit_adder #(
  parameter int unsigned DIGIT = 1
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             cin,
  output logic [DIGIT-1:0] s,
  output logic             cout,
  output logic             c_msb_in
);

  logic [DIGIT:0] c;

  // Full-adder chain, carry rippling from bit 0 upward.
  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = cin;
    for (int i = 0; i < int'(DIGIT); i++) begin
      s[i]   = x[i] ^ y[i] ^ c[i];
      c[i+1] = (x[i] & y[i]) | (x[i] & c[i]) | (y[i] & c[i]);
    end
  end

  assign cout     = c[DIGIT];
  assign c_msb_in = c[DIGIT-1];

endmodule

// File: rtl/serial_adder.sv
// Digit-serial adder/subtractor: processes WIDTH-bit operands DIGIT bits per
// clock, LSB first, with a registered carry between digits.
//   clk, rst  : rising-edge clock, asynchronous active-high reset
//   start     : begin an operation (ignored while busy)
//   sub       : 0 = a+b, 1 = a-b (sampled with start)
//   a, b      : operands (sampled with start)
//   busy      : operation in progress
//   done      : one-cycle pulse when sum/c_out/overflow are updated
//   sum       : result modulo 2^WIDTH
//   c_out     : carry out of MSB (subtract: 1 = no borrow)
//   overflow  : signed overflow
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             overflow
);

  localparam int unsigned NDIG = WIDTH / DIGIT;
  localparam int unsigned CW   = cnt_width(NDIG);

  // Reject illegal parameter combinations at elaboration.
  if ((WIDTH < 2) || (DIGIT < 1) || ((WIDTH % DIGIT) != 0)) begin : gen_param_check
    $error("serial_adder: WIDTH must be >= 2 and a multiple of DIGIT");
  end

  state_t            state, state_nxt;
  logic [WIDTH-1:0]  areg, breg;
  logic              carry;
  logic [CW-1:0]     cnt;
  logic              load, step, fin;

  logic [DIGIT-1:0]  dsum;
  logic              dcout, dcmsb;
  logic [WIDTH-1:0]  p_nxt;

  digit_adder #(.DIGIT(DIGIT)) u_digit (
    .x        (areg[DIGIT-1:0]),
    .y        (breg[DIGIT-1:0]),
    .cin      (carry),
    .s        (dsum),
    .cout     (dcout),
    .c_msb_in (dcmsb)
  );

  // Partial result: earlier digits sit below the digit being produced now.
  // With a single digit there is nothing to remember.
  if (NDIG == 1) begin : gen_single
    assign p_nxt = dsum;
  end else begin : gen_multi
    logic [WIDTH-DIGIT-1:0] preg;
    assign p_nxt = {dsum, preg};
    always_ff @(posedge clk or posedge rst) begin
      if (rst)       preg <= '0;
      else if (step) preg <= p_nxt[WIDTH-1:DIGIT];
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and datapath strobes.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    fin       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (cnt == CW'(NDIG - 1)) begin
          fin       = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand shifters, carry and digit counter. Subtraction is a + ~b + 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      areg  <= '0;
      breg  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
    end else if (load) begin
      areg  <= a;
      breg  <= sub ? ~b : b;
      carry <= sub;
      cnt   <= '0;
    end else if (step) begin
      areg  <= areg >> DIGIT;
      breg  <= breg >> DIGIT;
      carry <= dcout;
      cnt   <= cnt + CW'(1);
    end
  end

  // Result registers change only on the completion edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum      <= '0;
      c_out    <= 1'b0;
      overflow <= 1'b0;
    end else if (fin) begin
      sum      <= p_nxt;
      c_out    <= dcout;
      overflow <= dcout ^ dcmsb;
    end
  end

  // Handshake outputs decoded from the next state so they align with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (state_nxt == RUN);
      done <= (state_nxt == DONE);
    end
  end

endmodule
